gaussian_stat_estimator: RTL
============================

// Module: gaussian_stat_estimator
// PURPOSE
//   Receive side of the noise path: consumes a stream of Q7 (2^7-quantised) signed samples and
//   measures their mean and standard deviation over a window of 2^LOG2_N valid samples.
//   Used to calibrate and check the Gaussian noise sources against their programmed MEAN/STD.
//   Each measurement is started on request and returns both results with a done pulse.
// PARAMETERS
//   LOG2_N     10   log2 of window length in accepted samples (legal 4..16)
//   DATA_W     16   sample width, signed, fixed Q7 (FRAC_BITS=7 from package)
// PORTS
//   clk          in   1        single clock, all logic rising-edge
//   rst          in   1        asynchronous, active-low reset
//   start_i      in   1        begin a measurement (honoured only in IDLE)
//   valid_i      in   1        sample_i valid this cycle
//   sample_i     in   DATA_W   signed Q7 sample
//   busy_o       out  1        high from cycle after accepted start until done_o cycle inclusive
//   done_o       out  1        one-cycle pulse, mean_o/std_o updated same cycle
//   mean_o       out  DATA_W   signed Q7 mean estimate
//   std_o        out  DATA_W   unsigned Q7 std-dev estimate
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; busy_o=0, done_o=0, mean_o=0, std_o=0, all accumulators/counters 0.
//   States: IDLE -start_i-> ACCUM -count==2^LOG2_N-> VAR -> SQRT(16 cyc) -> DONE -> IDLE.
//   IDLE: start_i clears sum/sumsq/count; valid_i in the start_i cycle is NOT counted.
//   ACCUM: each cycle with valid_i=1 adds x to sum (signed, DATA_W+LOG2_N bits) and x*x to sumsq
//     (unsigned, 2*DATA_W+LOG2_N bits); count increments. Gaps in valid_i are legal, no timeout.
//   VAR (1 cyc): mean = sum >>> LOG2_N (arith shift, floor); ex2 = sumsq >> LOG2_N (Q14);
//     var = ex2 - mean*mean (Q14, 32b); negative result clamps to 0.
//   SQRT: restoring integer sqrt of var, one result bit per cycle, 16 cycles -> 16b Q7 std, floor.
//   DONE (1 cyc): done_o=1, mean_o/std_o loaded; outputs hold until next DONE.
//   Latency: last sample accepted in cycle T -> done_o high in cycle T+18, exactly.
//   start_i outside IDLE: ignored (no restart, no queueing). valid_i outside ACCUM: ignored.
//   Reset mid-measurement: abort immediately to reset values; no done_o for aborted window.
//   Overflow impossible by width rules: |x|<=2^15 -> x*x<=2^30, ex2<2^31, std<2^16.
// CONFIGURATION
//   GAUSS_EST_CLIP_CNT_EN defined: adds port clip_cnt_o out LOG2_N+1 bits, count of accepted samples
//     equal to 16'sh7FFF or 16'sh8000 in the window; reset 0, loaded in DONE alongside mean_o.
//   Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   Package gauss_est_pkg: state enum (IDLE, ACCUM, VAR, SQRT, DONE), FRAC_BITS=7,
//     SQRT_ITERS=16, SAT_POS/SAT_NEG constants.
//   Sub-module isqrt_seq: start/valid handshake, 32b unsigned in, 16b floor sqrt out,
//     fixed 16-cycle latency; top FSM owns accumulators and result registers.
// TESTING
//   1024 x 16'sd128 (1.0) -> mean_o=128, std_o=0, done_o exactly 18 cyc after last valid.
//   Alternating +256/-256, 1024 samples -> mean_o=0, var=65536, std_o=256.
//   1024 x 16'shFFFF -> mean_o=-1 (floor), std_o=0; start_i pulsed in ACCUM/SQRT ignored.
//   Case 2 with valid_i at 50% random duty -> identical results, exactly 1024 counted.
//   rst low at sample 500 -> busy_o=0, outputs 0, no done_o; restart -> correct case-1 result.
//   Random samples vs bench floor model (mean, clamp, isqrt) -> bit-exact over 50 windows;
//     with GAUSS_EST_CLIP_CNT_EN, 3x 7FFF + 2x 8000 in window -> clip_cnt_o=5.

Source files
------------

// File: rtl/gauss_est_pkg.sv
// Shared types and constants for the Gaussian noise statistics estimator.
package gauss_est_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        VAR,
        SQRT,
        DONE
    } est_state_t;

    localparam int FRAC_BITS  = 7;
    localparam int SQRT_ITERS = 16;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root: 32-bit radicand in, 16-bit floor root out.
// One root bit per cycle; the first bit is resolved in the start cycle, valid pulses 16 cycles after start.
module isqrt_seq
    import gauss_est_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] radicand,
    output logic        valid,
    output logic [15:0] root
);

    logic [31:0] rad_q;
    logic [17:0] rem_q;
    logic [15:0] root_q;
    logic [4:0]  cnt_q;
    logic        run_q;

    logic [17:0] src_rem;
    logic [15:0] src_root;
    logic [1:0]  src_pair;
    logic [19:0] trial_rem;
    logic [19:0] trial;
    logic [17:0] nxt_rem;
    logic [15:0] nxt_root;

    // A start cycle seeds the iteration from the fresh radicand instead of the held state
    always_comb begin
        src_rem   = start ? 18'd0 : rem_q;
        src_root  = start ? 16'd0 : root_q;
        src_pair  = start ? radicand[31:30] : rad_q[31:30];
        trial_rem = {src_rem, src_pair};
        trial     = {2'b00, src_root, 2'b01};
        if (trial_rem >= trial) begin
            nxt_rem  = 18'(trial_rem - trial);
            nxt_root = {src_root[14:0], 1'b1};
        end else begin
            nxt_rem  = 18'(trial_rem);
            nxt_root = {src_root[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                rad_q  <= {radicand[29:0], 2'b00};
                rem_q  <= nxt_rem;
                root_q <= nxt_root;
                cnt_q  <= 5'(SQRT_ITERS - 1);
                run_q  <= 1'b1;
            end else if (run_q) begin
                rad_q  <= {rad_q[29:0], 2'b00};
                rem_q  <= nxt_rem;
                root_q <= nxt_root;
                cnt_q  <= cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    run_q <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

    assign root = root_q;

endmodule

// File: rtl/gaussian_stat_estimator.sv
// Windowed mean / standard-deviation estimator for Q7 noise samples.
// Optional clip counter enabled by defining GAUSS_EST_CLIP_CNT_EN.
module gaussian_stat_estimator
    import gauss_est_pkg::*;
#(
    parameter int LOG2_N = 10,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     valid_i,
    input  logic signed [DATA_W-1:0] sample_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic signed [DATA_W-1:0] mean_o,
    output logic        [DATA_W-1:0] std_o
`ifdef GAUSS_EST_CLIP_CNT_EN
    ,
    output logic        [LOG2_N:0]   clip_cnt_o
`endif
);

    localparam int SUM_W = DATA_W + LOG2_N;
    localparam int SQ_W  = 2 * DATA_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);

    est_state_t state_q, state_d;

    logic signed [SUM_W-1:0]    sum_q;
    logic        [SQ_W-1:0]     sumsq_q;
    logic        [CNT_W-1:0]    count_q;
    logic signed [DATA_W-1:0]   mean_q;

    logic signed [2*DATA_W-1:0] sample_wide;
    logic        [2*DATA_W-1:0] sample_sq;
    logic signed [DATA_W-1:0]   mean_c;
    logic signed [2*DATA_W-1:0] mean_wide;
    logic        [2*DATA_W-1:0] mean_sq;
    logic        [2*DATA_W-1:0] ex2_c;
    logic signed [2*DATA_W:0]   var_diff;
    logic        [2*DATA_W-1:0] var_c;

    logic        sqrt_valid;
    logic [15:0] sqrt_root;

`ifdef GAUSS_EST_CLIP_CNT_EN
    logic [LOG2_N:0] clip_q;
    logic            is_sat;
    assign is_sat = ($unsigned(sample_i) == DATA_W'(SAT_POS)) ||
                    ($unsigned(sample_i) == DATA_W'(SAT_NEG));
`endif

    // Taking the upper slices of the accumulators is the divide-by-window (floor for the signed sum)
    always_comb begin
        sample_wide = sample_i;
        sample_sq   = sample_wide * sample_wide;
        mean_c      = sum_q[SUM_W-1:LOG2_N];
        mean_wide   = mean_c;
        mean_sq     = mean_wide * mean_wide;
        ex2_c       = sumsq_q[SQ_W-1:LOG2_N];
        var_diff    = $signed({1'b0, ex2_c}) - $signed({1'b0, mean_sq});
        var_c       = var_diff[2*DATA_W] ? '0 : var_diff[2*DATA_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = ACCUM;
            ACCUM:   if (valid_i && (count_q == LAST_CNT)) state_d = VAR;
            VAR:     state_d = SQRT;
            SQRT:    if (sqrt_valid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Results are loaded on the edge into DONE so they appear together with done_o
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q      <= '0;
            sumsq_q    <= '0;
            count_q    <= '0;
            mean_q     <= '0;
            mean_o     <= '0;
            std_o      <= '0;
`ifdef GAUSS_EST_CLIP_CNT_EN
            clip_q     <= '0;
            clip_cnt_o <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        sum_q   <= '0;
                        sumsq_q <= '0;
                        count_q <= '0;
`ifdef GAUSS_EST_CLIP_CNT_EN
                        clip_q  <= '0;
`endif
                    end
                end
                ACCUM: begin
                    if (valid_i) begin
                        sum_q   <= sum_q + SUM_W'(sample_i);
                        sumsq_q <= sumsq_q + SQ_W'(sample_sq);
                        count_q <= count_q + CNT_W'(1);
`ifdef GAUSS_EST_CLIP_CNT_EN
                        if (is_sat) clip_q <= clip_q + CNT_W'(1);
`endif
                    end
                end
                VAR: mean_q <= mean_c;
                SQRT: begin
                    if (sqrt_valid) begin
                        mean_o     <= mean_q;
                        std_o      <= DATA_W'(sqrt_root);
`ifdef GAUSS_EST_CLIP_CNT_EN
                        clip_cnt_o <= clip_q;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    isqrt_seq u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (state_q == VAR),
        .radicand (var_c),
        .valid    (sqrt_valid),
        .root     (sqrt_root)
    );

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

endmodule
